fproc_meas_buf: RTL and testbench

FPROC_MEAS_BUF -- requirements
Module: fproc_meas_buf

---
 rtl/fproc_meas_pkg.sv | 9 +
 rtl/fproc_meas_core_fsm.sv | 89 ++++++++
 rtl/fproc_meas_buf.sv | 61 ++++++
 tb/tb_fproc_meas_buf.sv | 136 +++++++++++++
 4 files changed

// File: rtl/fproc_meas_pkg.sv
// fproc_meas_pkg: shared state enum, request-mode constants and id-width helper for the measurement buffer.
package fproc_meas_pkg;
   typedef enum logic {IDLE, WAIT} state_t;
   localparam logic MODE_NEXT = 1'b0;
   localparam logic MODE_LATEST = 1'b1;
   function automatic int id_width(input int n);
      return ($clog2(n) + 1 > 1) ? $clog2(n) + 1 : 1;
   endfunction
endpackage

// File: rtl/fproc_meas_core_fsm.sv
// fproc_meas_core_fsm: per-core request FSM serving one core from the shared measurement channels.
// Optional WAIT timeout is built only when FPROC_MEAS_TIMEOUT_EN is defined.
module fproc_meas_core_fsm
   import fproc_meas_pkg::*;
#(
   parameter int N_MEAS = 5,
   parameter int MEAS_WIDTH = 1,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int ID_W = id_width(N_MEAS)
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         enable,
   input  logic                         mode,
   input  logic [ID_W-1:0]              id,
   input  logic [N_MEAS-1:0]            avail,
   input  logic [N_MEAS-1:0]            meas_valid,
   input  logic [N_MEAS*MEAS_WIDTH-1:0] meas,
   input  logic [N_MEAS*MEAS_WIDTH-1:0] meas_reg,
   output logic                         ready,
   output logic                         err,
   output logic [DATA_WIDTH-1:0]        data
);
   state_t state;
   logic [ID_W-1:0] addr;
   logic id_ok, id_avail, addr_valid, expired;
   logic [MEAS_WIDTH-1:0] id_stored, addr_live;
   // Loop muxes keep out-of-range ids from ever indexing the channel vectors.
   always_comb begin
      id_ok = 1'b0;
      id_avail = 1'b0;
      id_stored = '0;
      addr_valid = 1'b0;
      addr_live = '0;
      for (int j = 0; j < N_MEAS; j++) begin
         if (id == ID_W'(j)) begin
            id_ok = 1'b1;
            id_avail = avail[j];
            id_stored = meas_reg[j*MEAS_WIDTH +: MEAS_WIDTH];
         end
         if (addr == ID_W'(j)) begin
            addr_valid = meas_valid[j];
            addr_live = meas[j*MEAS_WIDTH +: MEAS_WIDTH];
         end
      end
   end
`ifdef FPROC_MEAS_TIMEOUT_EN
   localparam int CNT_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0] cnt;
   assign expired = state == WAIT && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clk) begin
      if (!reset_n || state != WAIT || addr_valid || expired) cnt <= '0;
      else cnt <= cnt + 1'b1;
   end
`else
   assign expired = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         addr <= '0;
         ready <= 1'b0;
         err <= 1'b0;
         data <= '0;
      end else begin
         ready <= 1'b0;
         err <= 1'b0;
         data <= '0;
         if (state == IDLE && enable) begin
            if (!id_ok) begin
               ready <= 1'b1;
               err <= 1'b1;
            end else if (mode == MODE_LATEST && id_avail) begin
               ready <= 1'b1;
               data <= DATA_WIDTH'(id_stored);
            end else begin
               addr <= id;
               state <= WAIT;
            end
         end else if (state == WAIT && (addr_valid || expired)) begin
            ready <= 1'b1;
            err <= !addr_valid;
            data <= addr_valid ? DATA_WIDTH'(addr_live) : '0;
            state <= IDLE;
         end
      end
   end
endmodule

// File: rtl/fproc_meas_buf.sv
// fproc_meas_buf: captures measurement strobes and serves per-core NEXT/LATEST requests.
// Define FPROC_MEAS_TIMEOUT_EN to add the per-core WAIT timeout.
module fproc_meas_buf
   import fproc_meas_pkg::*;
#(
   parameter int N_CORES = 5,
   parameter int N_MEAS = N_CORES,
   parameter int MEAS_WIDTH = 1,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int ID_W = id_width(N_MEAS)
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [N_MEAS*MEAS_WIDTH-1:0] meas,
   input  logic [N_MEAS-1:0]            meas_valid,
   input  logic [N_CORES-1:0]           core_enable,
   input  logic [N_CORES*ID_W-1:0]      core_id,
   input  logic [N_CORES-1:0]           core_mode,
   output logic [N_CORES-1:0]           core_ready,
   output logic [N_CORES*DATA_WIDTH-1:0] core_data,
   output logic [N_CORES-1:0]           core_err
);
   logic [N_MEAS-1:0] avail;
   logic [N_MEAS*MEAS_WIDTH-1:0] meas_reg;
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         avail <= '0;
         meas_reg <= '0;
      end else begin
         for (int j = 0; j < N_MEAS; j++) begin
            if (meas_valid[j]) begin
               avail[j] <= 1'b1;
               meas_reg[j*MEAS_WIDTH +: MEAS_WIDTH] <= meas[j*MEAS_WIDTH +: MEAS_WIDTH];
            end
         end
      end
   end
   for (genvar i = 0; i < N_CORES; i++) begin : g_core
      fproc_meas_core_fsm #(
         .N_MEAS(N_MEAS),
         .MEAS_WIDTH(MEAS_WIDTH),
         .DATA_WIDTH(DATA_WIDTH),
         .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
         .ID_W(ID_W)
      ) u_fsm (
         .clk(clk),
         .reset_n(reset_n),
         .enable(core_enable[i]),
         .mode(core_mode[i]),
         .id(core_id[i*ID_W +: ID_W]),
         .avail(avail),
         .meas_valid(meas_valid),
         .meas(meas),
         .meas_reg(meas_reg),
         .ready(core_ready[i]),
         .err(core_err[i]),
         .data(core_data[i*DATA_WIDTH +: DATA_WIDTH])
      );
   end
endmodule

// File: tb/tb_fproc_meas_buf.sv
// tb_fproc_meas_buf: directed and random requests scored against a queue-based reference model.
module tb_fproc_meas_buf;
   import fproc_meas_pkg::*;
   localparam int NC = 5, NM = 5, MW = 3, DW = 8, TO = 4;
   localparam int IW = id_width(NM);
   typedef struct {int t; logic [DW-1:0] d; logic e;} rsp_t;
   logic clk = 1'b0, reset_n = 1'b0;
   logic [NM*MW-1:0] meas = '0;
   logic [NM-1:0] meas_valid = '0;
   logic [NC-1:0] core_enable = '0, core_mode = '0, core_ready, core_err;
   logic [NC*IW-1:0] core_id = '0;
   logic [NC*DW-1:0] core_data;
   int cyc = 0, vectors = 0, miscompares = 0;
   rsp_t exp_q[NC][$];
   bit av[NM], pend[NC];
   logic [MW-1:0] st[NM];
   int pa[NC], pw[NC];

   fproc_meas_buf #(.N_CORES(NC), .N_MEAS(NM), .MEAS_WIDTH(MW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset_n(reset_n), .meas(meas), .meas_valid(meas_valid), .core_enable(core_enable),
      .core_id(core_id), .core_mode(core_mode), .core_ready(core_ready), .core_data(core_data), .core_err(core_err));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic push(input int c, input logic [MW-1:0] d, input logic e);
      exp_q[c].push_back(rsp_t'{cyc + 1, DW'(d), e});
   endtask

   // Reference: one request per idle core, served from stored value, live strobe, or error.
   task automatic model_step();
      int id;
      if (!reset_n) begin
         for (int j = 0; j < NM; j++) begin av[j] = 0; st[j] = '0; end
         for (int c = 0; c < NC; c++) pend[c] = 0;
         return;
      end
      for (int c = 0; c < NC; c++) begin
         if (pend[c]) begin
            pw[c]++;
            if (meas_valid[pa[c]]) begin push(c, meas[pa[c]*MW +: MW], 1'b0); pend[c] = 0; end
`ifdef FPROC_MEAS_TIMEOUT_EN
            else if (pw[c] == TO) begin push(c, '0, 1'b1); pend[c] = 0; end
`endif
         end else if (core_enable[c]) begin
            id = int'(core_id[c*IW +: IW]);
            if (id >= NM) push(c, '0, 1'b1);
            else if (core_mode[c] == MODE_LATEST && av[id]) push(c, st[id], 1'b0);
            else begin pend[c] = 1; pa[c] = id; pw[c] = 0; end
         end
      end
      for (int j = 0; j < NM; j++) if (meas_valid[j]) begin av[j] = 1; st[j] = meas[j*MW +: MW]; end
   endtask

   task automatic go();
      model_step();
      @(negedge clk);
      core_enable = '0;
      meas_valid = '0;
      reset_n = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) go();
   endtask

   task automatic req(input int c, input int id, input logic m);
      core_enable[c] = 1'b1;
      core_id[c*IW +: IW] = IW'(id);
      core_mode[c] = m;
   endtask

   task automatic strobe(input int j, input int v);
      meas_valid[j] = 1'b1;
      meas[j*MW +: MW] = MW'(v);
   endtask

   always @(negedge clk) begin
      rsp_t r;
      for (int c = 0; c < NC; c++) begin
         while (exp_q[c].size() > 0 && exp_q[c][0].t < cyc) begin
            r = exp_q[c].pop_front();
            miscompares++;
            $display("FAIL core%0d missed response due @%0d (data=%h err=%b)", c, r.t, r.d, r.e);
         end
         vectors++;
         if (exp_q[c].size() > 0 && exp_q[c][0].t == cyc) begin
            r = exp_q[c].pop_front();
            if (core_ready[c] !== 1'b1 || core_data[c*DW +: DW] !== r.d || core_err[c] !== r.e) begin
               miscompares++;
               $display("FAIL core%0d rsp @%0d: got ready=%b data=%h err=%b, want ready=1 data=%h err=%b",
                        c, cyc, core_ready[c], core_data[c*DW +: DW], core_err[c], r.d, r.e);
            end
         end else if (core_ready[c] !== 1'b0 || core_data[c*DW +: DW] !== '0 || core_err[c] !== 1'b0) begin
            miscompares++;
            $display("FAIL core%0d quiet @%0d: got ready=%b data=%h err=%b, want all zero",
                     c, cyc, core_ready[c], core_data[c*DW +: DW], core_err[c]);
         end
      end
   end

   initial begin
      @(negedge clk);
      reset_n = 1'b0;
      go();
      idle(2);
      req(0, 2, MODE_NEXT); go(); idle(2); strobe(2, 1); go(); idle(3);
      strobe(1, 1); go(); go(); req(1, 1, MODE_LATEST); go(); idle(2);
      req(1, 1, MODE_NEXT); go(); idle(5); strobe(1, 5); go(); idle(2);
      req(2, 3, MODE_NEXT); strobe(3, 2); go(); idle(3); strobe(3, 6); go(); idle(2);
      req(3, 7, MODE_NEXT); go(); idle(2);
      for (int k = 0; k < 3; k++) begin req(3, 1, MODE_LATEST); go(); end
      idle(2);
      req(0, 0, MODE_NEXT); go();
`ifdef FPROC_MEAS_TIMEOUT_EN
      idle(10);
`else
      idle(1000);
`endif
      strobe(0, 3); go(); idle(2);
      req(0, 0, MODE_NEXT); req(4, 0, MODE_NEXT); go(); idle(2);
      reset_n = 1'b0; go(); strobe(0, 1); go(); idle(3);
      req(0, 0, MODE_NEXT); req(4, 0, MODE_NEXT); go(); idle(1); strobe(0, 4); go(); idle(2);
      for (int k = 0; k < 3000; k++) begin
         for (int c = 0; c < NC; c++)
            if ($urandom_range(0, 3) == 0) req(c, int'($urandom_range(0, NM + 1)), 1'($urandom_range(0, 1)));
         for (int j = 0; j < NM; j++)
            if ($urandom_range(0, 5) == 0) strobe(j, int'($urandom_range(0, 7)));
         if ($urandom_range(0, 299) == 0) reset_n = 1'b0;
         go();
      end
      idle(TO + 5);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
